serial_subtractor: RTL



---
 rtl/subtractor_pkg.sv | 22 ++
 rtl/ripple_subtractor.sv | 47 ++++
 rtl/serial_subtractor.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/subtractor_pkg.sv
// subtractor_pkg
// Shared definitions for the serial subtractor:
//   state_t      - FSM state encoding (IDLE, RUN, DONE)
//   digit_count  - number of DIGIT-wide digits in a WIDTH-bit operand
//   cnt_width    - digit counter width, clog2(N) with a minimum of 1
package subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ripple_subtractor.sv
// full_subtractor / ripple_subtractor
// One-bit full subtractor cell and a W-bit ripple chain built from it.
// ripple_subtractor ports:
//   a, b      - W-bit minuend / subtrahend
//   bin       - borrow into bit 0
//   diff      - W-bit difference a - b - bin
//   bout      - borrow out of bit W-1
//   b_msb_in  - borrow into bit W-1 (used for signed overflow)
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module ripple_subtractor #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         b_msb_in
);
    // w_borrow[i] is the borrow into bit i; w_borrow[W] leaves the chain
    logic [W:0] w_borrow;

    assign w_borrow[0] = bin;

    for (genvar i = 0; i < W; i++) begin : g_cell
        full_subtractor u_fs (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (w_borrow[i]),
            .d    (diff[i]),
            .bout (w_borrow[i+1])
        );
    end

    assign bout     = w_borrow[W];
    assign b_msb_in = w_borrow[W-1];
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Multi-cycle A - B - Bin over WIDTH bits, DIGIT bits per clock, LSB digit
// first, with a start/done handshake and registered status flags.
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   start              - request, sampled only when not busy
//   A, B, Bin          - operands, captured on an accepted start
//   busy               - high while the digits are being processed
//   done               - one-cycle pulse, result valid
//   Diff, Bout         - result and borrow out of bit WIDTH-1
//   Zero, Ovf          - Diff == 0, signed two's-complement overflow
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero,
    output logic             Ovf
);
    import subtractor_pkg::*;

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_subtractor: illegal WIDTH/DIGIT combination");
    end

    localparam int N  = digit_count(WIDTH, DIGIT);
    localparam int CW = cnt_width(N);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_borrow;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_zero;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic [DIGIT-1:0]   w_a_dig;
    logic [DIGIT-1:0]   w_b_dig;
    logic [DIGIT-1:0]   w_dig_diff;
    logic               w_dig_bout;
    logic               w_dig_msb_in;
    logic [WIDTH-1:0]   w_merged;
    logic               w_busy;
    logic               w_done;

    // A start is only honoured outside RUN; the DONE cycle accepts it too
    assign w_accept = start && (r_state != ST_RUN);
    assign w_last   = (r_cnt == CW'(N - 1));

    // Digit mux: select the operand digit addressed by the counter
    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_dig = r_a[k*DIGIT +: DIGIT];
                w_b_dig = r_b[k*DIGIT +: DIGIT];
            end
        end
    end

    ripple_subtractor #(.W(DIGIT)) u_ripple (
        .a        (w_a_dig),
        .b        (w_b_dig),
        .bin      (r_borrow),
        .diff     (w_dig_diff),
        .bout     (w_dig_bout),
        .b_msb_in (w_dig_msb_in)
    );

    // The top digit is never stored in r_work; it is merged straight into
    // the result on the completing edge.
    always_comb begin
        w_merged = r_work;
        w_merged[(N-1)*DIGIT +: DIGIT] = w_dig_diff;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_next_state = ST_RUN;
            ST_RUN:  if (w_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = start ? ST_RUN : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM: outputs decoded from the state register
    always_comb begin
        w_busy = (r_state == ST_RUN);
        w_done = (r_state == ST_DONE);
    end

    // Datapath: operand capture, digit processing, result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_work   <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= Bin;
            r_cnt    <= '0;
        end else if (r_state == ST_RUN) begin
            r_borrow <= w_dig_bout;
            r_cnt    <= r_cnt + 1'b1;
            for (int k = 0; k < N - 1; k++) begin
                if (r_cnt == CW'(k)) begin
                    r_work[k*DIGIT +: DIGIT] <= w_dig_diff;
                end
            end
            if (w_last) begin
                r_diff <= w_merged;
                r_bout <= w_dig_bout;
                r_zero <= (w_merged == '0);
                r_ovf  <= w_dig_msb_in ^ w_dig_bout;
            end
        end
    end

    assign busy = w_busy;
    assign done = w_done;
    assign Diff = r_diff;
    assign Bout = r_bout;
    assign Zero = r_zero;
    assign Ovf  = r_ovf;

endmodule
